// File: rtl/uart_pkg.sv
// Shared UART constants and small helpers used by the receive-side blocks.
package uart_pkg;

    localparam int UART_DATA_WIDTH   = 8;
    localparam int RX_FIFO_DEPTH     = 8;
    localparam int RX_FIFO_AF_THRESH = 6;
    localparam int DROP_CNT_W        = 8;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic drop_cnt_t sat_inc(input drop_cnt_t value);
        return (&value) ? value : value + drop_cnt_t'(1);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto plain RAM/regfile cells; the
    // owner guarantees no output depends on an entry that was never written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: first-word-fall-through FIFO behind the UART RX
// controller with fill level, almost-full, sticky overflow and drop count.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = RX_FIFO_DEPTH,
    parameter int AF_THRESH  = RX_FIFO_AF_THRESH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_data_valid,
    input  logic [DATA_WIDTH-1:0]      rx_p_data,
    output logic                       rd_valid,
    output logic [DATA_WIDTH-1:0]      rd_data,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [DROP_CNT_W-1:0]      drop_cnt
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      level_next;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  empty;
    logic                  full;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  drop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    assign rd_valid = !empty;
    assign rd_fire  = rd_valid & rd_ready;
    assign wr_fire  = rx_data_valid & (!full | rd_fire);
    assign drop     = rx_data_valid & full & !rd_fire;

    assign rd_data = rd_valid ? mem_rd_data : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        level_next = level;
        unique case ({wr_fire, rd_fire})
            2'b10:   level_next = level + PTR_W'(1);
            2'b01:   level_next = level - PTR_W'(1);
            default: level_next = level;
        endcase
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (rx_p_data),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (mem_rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level       <= level_next;
            almost_full <= (level_next >= AF_LEVEL);
        end
    end

    // A drop in the same cycle as a clear wins: the flag stays set and the
    // count restarts at one for the byte just lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= ovf_clr ? drop_cnt_t'(1) : sat_inc(drop_cnt);
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random
// traffic compared against a queue-based model of the buffer.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = RX_FIFO_DEPTH;
    localparam int AF    = RX_FIFO_AF_THRESH;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_data_valid = 1'b0;
    logic [7:0]    rx_p_data = '0;
    logic          rd_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          overflow;
    logic [7:0]    drop_cnt;

    uart_rx_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_valid (rx_data_valid),
        .rx_p_data     (rx_p_data),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .level         (level),
        .almost_full   (almost_full),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: contents as a queue, flags as plain variables.
    byte unsigned m_q[$];
    bit           m_ovf  = 1'b0;
    int           m_drop = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    task automatic check_state(input string tag);
        int unsigned exp_data;
        exp_data = (m_q.size() > 0) ? m_q[0] : 0;
        check({tag, ".level"},    32'(level),       32'(m_q.size()));
        check({tag, ".rd_valid"}, 32'(rd_valid),    32'(m_q.size() > 0));
        check({tag, ".rd_data"},  32'(rd_data),     exp_data);
        check({tag, ".af"},       32'(almost_full), 32'(m_q.size() >= AF));
        check({tag, ".ovf"},      32'(overflow),    32'(m_ovf));
        check({tag, ".drop_cnt"}, 32'(drop_cnt),    32'(m_drop));
    endtask

    // One clock cycle: drive inputs, advance the model, step the clock, compare.
    task automatic cycle(input string tag, input bit v, input byte unsigned d,
                         input bit rdy, input bit clr);
        bit full;
        bit rd_fire;
        bit drop;
        byte unsigned popped;
        rx_data_valid = v;
        rx_p_data     = d;
        rd_ready      = rdy;
        ovf_clr       = clr;
        full    = (m_q.size() == DEPTH);
        rd_fire = rdy && (m_q.size() > 0);
        drop    = v && full && !rd_fire;
        if (rd_fire) begin
            popped = m_q.pop_front();
            check({tag, ".pop"}, 32'(rd_data), 32'(popped));
        end
        if (v && !drop) m_q.push_back(d);
        if (drop) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
        rd_ready      = 1'b0;
        ovf_clr       = 1'b0;
        check_state(tag);
    endtask

    task automatic drain(input string tag);
        int n;
        n = m_q.size();
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 check_state("reset_async");
        repeat (2) @(posedge clk);
        #1 check_state("reset_hold");
        rst = 1'b1;

        // Single byte with fall-through, then one read.
        cycle("single_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
        cycle("single_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("idle_rdy", 1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to full, one drop, drain in order.
        for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        check("fill.af_at_8", 32'(almost_full), 32'd1);
        cycle("drop1", 1'b1, 8'hFF, 1'b0, 1'b0);
        drain("drain1");
        cycle("clr1", 1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous read and write.
        for (int i = 0; i < 8; i++) cycle("fill2", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        cycle("full_rw", 1'b1, 8'h77, 1'b1, 1'b0);
        drain("drain2");

        // Overflow clear alone, then clear racing a drop.
        for (int i = 0; i < 8; i++) cycle("fill3", 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("drop3", 1'b1, 8'hD0, 1'b0, 1'b0);
        check("drop3.cnt", 32'(drop_cnt), 32'd3);
        cycle("clr_alone", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("clr_race", 1'b1, 8'hEE, 1'b0, 1'b1);

        // Saturation of the drop counter.
        for (int i = 0; i < 300; i++) cycle("sat", 1'b1, 8'(i), 1'b0, 1'b0);
        check("sat.cnt", 32'(drop_cnt), 32'd255);
        drain("drain4");
        cycle("clr4", 1'b0, 8'h00, 1'b0, 1'b1);

        // Streaming with rd_ready held high across pointer wrap.
        for (int i = 0; i < 20; i++) cycle("stream", 1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
        drain("drain5");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle("rand", $urandom_range(0, 99) < 60, 8'($urandom),
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5);
        end
        drain("drain6");

        // Asynchronous reset mid-stream with level 4 and overflow set.
        for (int i = 0; i < 9; i++) cycle("pre_rst", 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("pre_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst.level", 32'(level), 32'd4);
        #2 rst = 1'b0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        #1 check_state("mid_rst");
        @(posedge clk);
        #1 rst = 1'b1;
        check_state("post_rst");
        cycle("post_rst_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
        cycle("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
